paddle_position_ctrl: RTL and testbench
=======================================

// Module: paddle_position_ctrl
// PURPOSE
//  Upstream of the VGA display controller: owns both player paddles' centre coordinates.
//  Synchronises and debounces the eight raw direction buttons, then steps each paddle
//  once per video frame (rising edge of the timing generator's screenEnd), clamped to the player's half-screen.
//  Registered p1/p2 x/y outputs feed the display controller's paddle hit-test directly.
// PARAMETERS
//  SCREEN_W   640  visible width in pixels
//  SCREEN_H   480  visible height in pixels
//  HALF_W     25   paddle half-width (x clamp margin)
//  HALF_H     33   paddle half-height (y clamp margin)
//  P1_X0/P1_Y0 80/240   p1 reset position
//  P2_X0/P2_Y0 560/240  p2 reset position
//  STEP       1    pixels moved per frame per axis
//  DB_CYCLES  250000  clk cycles a synchronised button must be stable before it is accepted (2.5 ms at 100 MHz)
// PORTS
//  clk          in   1   100 MHz system clock
//  reset        in   1   asynchronous, active-high reset
//  frame_tick   in   1   screenEnd from timing generator (slow-domain level, synchronised here)
//  p1_up/down/left/right  in  1 each  raw buttons, active-high, asynchronous
//  p2_up/down/left/right  in  1 each  raw buttons, active-high, asynchronous
//  p1_x  out 10  p1 centre x;  p1_y  out 9  p1 centre y
//  p2_x  out 10  p2 centre x;  p2_y  out 9  p2 centre y
//  frame_update out 1  one-clk pulse, asserted in the cycle positions change
// BEHAVIOUR
//  - Reset (async assert, sync release): p1=(P1_X0,P1_Y0), p2=(P2_X0,P2_Y0), frame_update=0, synchronisers/debounce state=0, debounced buttons=0.
//  - Inputs: 2-flop synchroniser on every button and on frame_tick. Per-button debounce counter: restarts
//    on any change of synchronised value; debounced output takes the new value when counter reaches DB_CYCLES-1.
//  - Tick: 3rd flop on frame_tick; tick = sync & ~prev. Positions update on the clk edge after tick is
//    seen (1 cycle); frame_update high in that same cycle only. Ticks only on frame_tick 0->1 edges;
//    a held-high frame_tick yields exactly one update.
//  - Move per axis: up&~down -> y-=step; down&~up -> y+=step; both or neither -> y hold. x likewise with left/right.
//  - Clamp (saturate, never wrap; compute in 11-bit signed):
//      p1 x in [HALF_W, SCREEN_W/2-HALF_W]   p2 x in [SCREEN_W/2+HALF_W, SCREEN_W-1-HALF_W]
//      both y in [HALF_H, SCREEN_H-1-HALF_H]
//    A step that would pass a bound lands exactly on it; a paddle already at a bound stays there.
//  - Button change with no tick: positions hold. Tick during debounce: uses the previously accepted value.
//  - Reset mid-debounce or mid-frame: immediate return to reset state; first update needs a fresh tick edge after release.
// CONFIGURATION
//  PADDLE_ACCEL_EN defined: per-player 6-bit hold counter, +1 per tick while any direction is held (saturates at 63),
//    cleared on a tick with no direction held. Effective step = STEP<<min(hold>>4,2), i.e. 1x for 0-15, 2x for 16-31, 4x for 32+. Clamp rules unchanged.
//  Not defined: step is always STEP; no hold counter logic is built.
// TESTING (DB_CYCLES=4, defaults otherwise)
//  1 Reset, no buttons, 3 ticks -> p1=(80,240), p2=(560,240); frame_update pulses 3 times, 1 clk each.
//  2 p1_up held, 10 ticks -> p1_y=230, p1_x=80; p2 unchanged. frame_tick held high 50 clks counts as 1 tick.
//  3 p1_right held, 300 ticks -> p1_x saturates at 295; p2_left held, 300 ticks -> p2_x saturates at 345.
//  4 p2_up & p2_down held together, 5 ticks -> p2_y=240; 2-clk glitch on p1_left -> no p1 movement.
//  5 p1_down held 100 ticks, assert reset mid-run -> outputs at reset values the same cycle; after release no move until a new tick.
//  6 PADDLE_ACCEL_EN: p1_down held 20 ticks from 240 -> p1_y=264 (16x1 + 4x2); without the macro -> 260.

Source files
------------

// File: rtl/paddle_position_ctrl.sv
// Both paddles' centre coordinates: 2-flop synchronisers, per-button debounce, one clamped step per frame.
// Optional build macro PADDLE_ACCEL_EN adds a per-player hold counter that scales the step (1x/2x/4x).
module paddle_position_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int HALF_W    = 25,
  parameter int HALF_H    = 33,
  parameter int P1_X0     = 80,
  parameter int P1_Y0     = 240,
  parameter int P2_X0     = 560,
  parameter int P2_Y0     = 240,
  parameter int STEP      = 1,
  parameter int DB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p1_left,
  input  logic       p1_right,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       p2_left,
  input  logic       p2_right,
  output logic [9:0] p1_x,
  output logic [8:0] p1_y,
  output logic [9:0] p2_x,
  output logic [8:0] p2_y,
  output logic       frame_update
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] P1_XLO = 11'(HALF_W);
  localparam logic signed [10:0] P1_XHI = 11'(SCREEN_W / 2 - HALF_W);
  localparam logic signed [10:0] P2_XLO = 11'(SCREEN_W / 2 + HALF_W);
  localparam logic signed [10:0] P2_XHI = 11'(SCREEN_W - 1 - HALF_W);
  localparam logic signed [10:0] Y_LO   = 11'(HALF_H);
  localparam logic signed [10:0] Y_HI   = 11'(SCREEN_H - 1 - HALF_H);

  // Button bit order per player: up, down, left, right (p1 in [3:0], p2 in [7:4]).
  logic [7:0] btn_raw;
  assign btn_raw = {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up};

  logic [7:0]       btn_meta_q, btn_sync_q;
  logic [7:0]       btn_db_q, btn_db_d;
  logic [CNT_W-1:0] db_cnt_q [8];
  logic [CNT_W-1:0] db_cnt_d [8];
  logic             ft_meta_q, ft_sync_q, ft_prev_q;
  logic             tick;

  logic [9:0] p1_x_q, p1_x_d, p2_x_q, p2_x_d;
  logic [8:0] p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic       frame_update_q, frame_update_d;
  logic signed [10:0] p1_step, p2_step;

  function automatic logic signed [10:0] sat(input logic signed [10:0] v, lo, hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic signed [10:0] move(input logic signed [10:0] pos,
                                              input logic dec, inc,
                                              input logic signed [10:0] step, lo, hi);
    logic signed [10:0] v;
    v = pos;
    if (dec && !inc)      v = pos - step;
    else if (inc && !dec) v = pos + step;
    return sat(v, lo, hi);
  endfunction

  assign tick = ft_sync_q & ~ft_prev_q;

  // Debounce: counter runs only while the synchronised value disagrees with the accepted one.
  always_comb begin
    btn_db_d = btn_db_q;
    for (int i = 0; i < 8; i++) begin
      db_cnt_d[i] = '0;
      if (btn_sync_q[i] != btn_db_q[i]) begin
        if (db_cnt_q[i] == CNT_MAX) btn_db_d[i] = btn_sync_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

`ifdef PADDLE_ACCEL_EN
  logic [5:0] p1_hold_q, p1_hold_d, p2_hold_q, p2_hold_d;

  function automatic logic signed [10:0] accel_step(input logic [5:0] hold);
    logic [1:0] sh;
    sh = hold[5] ? 2'd2 : {1'b0, hold[4]};
    return STEP_S <<< sh;
  endfunction

  function automatic logic [5:0] hold_next(input logic [5:0] hold, input logic any);
    if (!any) return 6'd0;
    if (hold == 6'd63) return hold;
    return hold + 6'd1;
  endfunction

  assign p1_step = accel_step(p1_hold_q);
  assign p2_step = accel_step(p2_hold_q);

  always_comb begin
    p1_hold_d = p1_hold_q;
    p2_hold_d = p2_hold_q;
    if (tick) begin
      p1_hold_d = hold_next(p1_hold_q, |btn_db_q[3:0]);
      p2_hold_d = hold_next(p2_hold_q, |btn_db_q[7:4]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_hold_q <= '0;
      p2_hold_q <= '0;
    end else begin
      p1_hold_q <= p1_hold_d;
      p2_hold_q <= p2_hold_d;
    end
  end
`else
  assign p1_step = STEP_S;
  assign p2_step = STEP_S;
`endif

  // Position step: up/left decrement, down/right increment, result saturated to the player's region.
  always_comb begin
    p1_x_d         = p1_x_q;
    p1_y_d         = p1_y_q;
    p2_x_d         = p2_x_q;
    p2_y_d         = p2_y_q;
    frame_update_d = tick;
    if (tick) begin
      p1_x_d = 10'(move($signed({1'b0, p1_x_q}), btn_db_q[2], btn_db_q[3], p1_step, P1_XLO, P1_XHI));
      p1_y_d = 9'(move($signed({2'b0, p1_y_q}), btn_db_q[0], btn_db_q[1], p1_step, Y_LO, Y_HI));
      p2_x_d = 10'(move($signed({1'b0, p2_x_q}), btn_db_q[6], btn_db_q[7], p2_step, P2_XLO, P2_XHI));
      p2_y_d = 9'(move($signed({2'b0, p2_y_q}), btn_db_q[4], btn_db_q[5], p2_step, Y_LO, Y_HI));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q     <= '0;
      btn_sync_q     <= '0;
      btn_db_q       <= '0;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= '0;
      ft_meta_q      <= 1'b0;
      ft_sync_q      <= 1'b0;
      ft_prev_q      <= 1'b0;
      p1_x_q         <= 10'(P1_X0);
      p1_y_q         <= 9'(P1_Y0);
      p2_x_q         <= 10'(P2_X0);
      p2_y_q         <= 9'(P2_Y0);
      frame_update_q <= 1'b0;
    end else begin
      btn_meta_q     <= btn_raw;
      btn_sync_q     <= btn_meta_q;
      btn_db_q       <= btn_db_d;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= db_cnt_d[i];
      ft_meta_q      <= frame_tick;
      ft_sync_q      <= ft_meta_q;
      ft_prev_q      <= ft_sync_q;
      p1_x_q         <= p1_x_d;
      p1_y_q         <= p1_y_d;
      p2_x_q         <= p2_x_d;
      p2_y_q         <= p2_y_d;
      frame_update_q <= frame_update_d;
    end
  end

  assign p1_x         = p1_x_q;
  assign p1_y         = p1_y_q;
  assign p2_x         = p2_x_q;
  assign p2_y         = p2_y_q;
  assign frame_update = frame_update_q;

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Randomised bench for paddle_position_ctrl (DB_CYCLES=4) against a frame-level arithmetic model.
module tb_paddle_position_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       p1_up, p1_down, p1_left, p1_right;
  logic       p2_up, p2_down, p2_left, p2_right;
  logic [9:0] p1_x, p2_x;
  logic [8:0] p1_y, p2_y;
  logic       frame_update;

  always #5 clk = ~clk;

  paddle_position_ctrl #(.DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
    .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .frame_update(frame_update)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model state: positions, hold counters, accepted buttons (bit order up,down,left,right per player).
  int         ex[2], ey[2], hold[2];
  logic [7:0] acc, raw;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    ex[0] = 80;  ey[0] = 240;
    ex[1] = 560; ey[1] = 240;
    hold[0] = 0; hold[1] = 0;
    acc = 8'h00;
  endtask

  task automatic model_tick();
    for (int p = 0; p < 2; p++) begin
      logic [3:0] b;
      int st, dx, dy, sh;
      b  = acc[4*p +: 4];
      sh = 0;
`ifdef PADDLE_ACCEL_EN
      sh = hold[p] / 16;
      if (sh > 2) sh = 2;
      if (b != 4'b0) hold[p] = (hold[p] == 63) ? 63 : hold[p] + 1;
      else           hold[p] = 0;
`endif
      st = 1 << sh;
      dy = (b[1] && !b[0]) ? 1 : (b[0] && !b[1]) ? -1 : 0;
      dx = (b[3] && !b[2]) ? 1 : (b[2] && !b[3]) ? -1 : 0;
      ey[p] = clampi(ey[p] + dy * st, 33, 446);
      ex[p] = clampi(ex[p] + dx * st, (p == 0) ? 25 : 345, (p == 0) ? 295 : 614);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_raw(input logic [7:0] b);
    {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up} = b;
  endtask

  task automatic check_pos(input string tag);
    chk({tag, "_p1x"}, int'(p1_x), ex[0]);
    chk({tag, "_p1y"}, int'(p1_y), ey[0]);
    chk({tag, "_p2x"}, int'(p2_x), ex[1]);
    chk({tag, "_p2y"}, int'(p2_y), ey[1]);
  endtask

  // Change buttons with no tick: after settling the model accepts them; positions must not move.
  task automatic set_btn(input logic [7:0] b);
    int pulses;
    raw = b;
    drive_raw(b);
    pulses = 0;
    repeat (10) begin
      cyc();
      pulses += int'(frame_update);
    end
    acc = b;
    chk("btn_no_update", pulses, 0);
    check_pos("btn_hold");
  endtask

  // One frame_tick rising edge held 'hi' extra cycles after the update.
  task automatic do_tick(input int hi);
    int lat, pulses;
    frame_tick = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (frame_update) begin
        lat = i;
        break;
      end
    end
    chk("upd_latency", lat, 3);
    model_tick();
    check_pos("tick");
    pulses = 0;
    repeat (hi) begin
      cyc();
      pulses += int'(frame_update);
    end
    chk("upd_single_pulse", pulses, 0);
    frame_tick = 1'b0;
    repeat (4) cyc();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset = 1'b1;
    frame_tick = 1'b0;
    raw = 8'h00;
    drive_raw(raw);
    model_reset();
    #2;
    check_pos("reset");
    chk("reset_fu", int'(frame_update), 0);
    repeat (3) cyc();
    reset = 1'b0;
    repeat (3) cyc();

    // Idle ticks: no movement, one pulse each
    for (int i = 0; i < 3; i++) do_tick(2);

    // p1 up for 10 frames; one frame_tick held ~50 clocks
    set_btn(8'h01);
    for (int i = 0; i < 10; i++) do_tick((i == 4) ? 47 : 1);
    chk("p1_up_y", int'(p1_y), 230);
    chk("p1_up_x", int'(p1_x), 80);

    // Saturation at the inner x bounds
    set_btn(8'h48);
    for (int i = 0; i < 300; i++) do_tick(1);
    chk("p1_x_sat", int'(p1_x), 295);
    chk("p2_x_sat", int'(p2_x), 345);

    // Opposing buttons cancel; short glitch never accepted
    set_btn(8'h30);
    drive_raw(raw | 8'h04);
    cyc();
    cyc();
    drive_raw(raw);
    repeat (8) cyc();
    for (int i = 0; i < 5; i++) do_tick(1);
    chk("p2_updown_y", int'(p2_y), 240);
    chk("glitch_p1x", int'(p1_x), 295);

    // Reset in the middle of a run and of a pending tick
    set_btn(8'h02);
    for (int i = 0; i < 30; i++) do_tick(1);
    frame_tick = 1'b1;
    cyc();
    #2;
    reset = 1'b1;
    frame_tick = 1'b0;
    #1;
    model_reset();
    check_pos("async_reset");
    chk("async_reset_fu", int'(frame_update), 0);
    repeat (3) cyc();
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      cyc();
      pulses += int'(frame_update);
    end
    chk("post_reset_no_upd", pulses, 0);
    check_pos("post_reset");
    acc = raw;
    for (int i = 0; i < 20; i++) do_tick(1);
`ifdef PADDLE_ACCEL_EN
    chk("p1_down20_y", int'(p1_y), 264);
`else
    chk("p1_down20_y", int'(p1_y), 260);
`endif

    // Random button patterns, glitches and frame counts
    for (int ph = 0; ph < 20; ph++) begin
      logic [7:0] g;
      set_btn(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        g = 8'd1 << $urandom_range(0, 7);
        drive_raw(raw ^ g);
        repeat ($urandom_range(1, 2)) cyc();
        drive_raw(raw);
        repeat (8) cyc();
      end
      repeat ($urandom_range(1, 12)) do_tick($urandom_range(1, 6));
    end
    check_pos("final");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
